// File: rtl/excess3_decoder_pkg.sv
// Shared constants, state encoding and decoded-digit payload for the excess-3 decoder.
package excess3_decoder_pkg;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ERR_CNT_W = 8;

    localparam logic [NIBBLE_W-1:0] EXCESS3_OFFSET = 4'd3;
    localparam logic [NIBBLE_W-1:0] EXCESS3_MIN    = 4'h3;
    localparam logic [NIBBLE_W-1:0] EXCESS3_MAX    = 4'hC;
    localparam logic [NIBBLE_W-1:0] BCD_ERR_NIBBLE = 4'hF;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    typedef struct packed {
        logic                illegal;
        logic [NIBBLE_W-1:0] dec;
    } dec_digit_t;

endpackage

// File: rtl/excess3_decoder_digit_dec.sv
// Combinational single-digit excess-3 to BCD decode with illegal-code flag.
module excess3_digit_dec
    import excess3_decoder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] digit_i,
    output dec_digit_t          dec_o
);

    // Out-of-range codes substitute the error nibble so they stand out in the word.
    always_comb begin
        dec_o.illegal = 1'b0;
        dec_o.dec     = digit_i - EXCESS3_OFFSET;
        if ((digit_i < EXCESS3_MIN) || (digit_i > EXCESS3_MAX)) begin
            dec_o.illegal = 1'b1;
            dec_o.dec     = BCD_ERR_NIBBLE;
        end
    end

endmodule

// File: rtl/excess3_decoder.sv
// Digit-serial excess-3 to packed BCD word decoder with valid/ready on both sides.
// Optional saturating illegal-digit counter enabled by EXCESS3_ERR_CNT_EN.
module excess3_decoder
    import excess3_decoder_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W-1:0]          in_digit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*DIGITS-1:0]   out_bcd,
    output logic                         out_err
`ifdef EXCESS3_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]         err_count
`endif
);

    localparam int unsigned WORD_W = NIBBLE_W * DIGITS;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  shift_q, shift_d;
    logic               err_q, err_d;
    dec_digit_t         dec;
    logic               accept;

    excess3_digit_dec u_digit_dec (
        .digit_i (in_digit),
        .dec_o   (dec)
    );

    assign in_ready  = (state_q == ST_COLLECT);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign out_bcd   = shift_q;
    assign out_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            err_q   <= err_d;
        end
    end

    // Shifting by a whole nibble keeps DIGITS == 1 legal without a negative slice.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        err_d   = err_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (in_valid) begin
                    shift_d = (shift_q << NIBBLE_W) | WORD_W'(dec.dec);
                    err_d   = err_q | dec.illegal;
                    if (cnt_q == CNT_W'(DIGITS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_COLLECT;
                    shift_d = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

`ifdef EXCESS3_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && dec.illegal && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule
